main_control_fsm: RTL and testbench

Multi-cycle main control unit for the non-pipelined LEGv8 core. It sits directly upstream of `alu_control`. It decodes the 11-bit instruction opcode, sequences each instruction through fetch/decode/execute/memory/writeback states, and drives `alu_op` plus all datapath enables. It also handshakes with instruction and data memory that may insert wait states.

---
 rtl/main_control_fsm_pkg.sv | 41 ++++
 rtl/main_control_fsm_instr_class_decode.sv | 32 +++
 rtl/main_control_fsm.sv | 173 +++++++++++++++++
 tb/tb_main_control_fsm.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_control_fsm_pkg.sv
// Shared encodings for the LEGv8 multi-cycle main control: states, instruction
// classes, alu_op codes and opcode constants.
package main_control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_R  = 3'd0,
        CLS_SH = 3'd1,
        CLS_LD = 3'd2,
        CLS_ST = 3'd3,
        CLS_CB = 3'd4,
        CLS_B  = 3'd5
    } iclass_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_PASS_B = 2'b01;
    localparam logic [1:0] ALUOP_SHIFT  = 2'b10;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b11;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    // CBZ and B carry register/offset bits in the low opcode bits; match prefixes only
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  OP_B_PFX   = 6'b000101;

endpackage

// File: rtl/main_control_fsm_instr_class_decode.sv
// Combinational opcode classifier: maps an 11-bit LEGv8 opcode to its
// instruction class and flags anything unrecognised as illegal.
module instr_class_decode
    import main_control_fsm_pkg::*;
(
    input  logic [10:0] i_opcode,
    output iclass_t     o_class,
    output logic        o_illegal
);

    always_comb begin
        o_class   = CLS_R;
        o_illegal = 1'b0;
        if (i_opcode == OP_ADD || i_opcode == OP_SUB ||
            i_opcode == OP_AND || i_opcode == OP_ORR) begin
            o_class = CLS_R;
        end else if (i_opcode == OP_LSL || i_opcode == OP_LSR) begin
            o_class = CLS_SH;
        end else if (i_opcode == OP_LDUR) begin
            o_class = CLS_LD;
        end else if (i_opcode == OP_STUR) begin
            o_class = CLS_ST;
        end else if (i_opcode[10:3] == OP_CBZ_PFX) begin
            o_class = CLS_CB;
        end else if (i_opcode[10:5] == OP_B_PFX) begin
            o_class = CLS_B;
        end else begin
            o_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM for the non-pipelined LEGv8 core: sequences
// fetch/decode/execute/mem/writeback, drives datapath enables and counts retires.
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             reg2_loc,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_write,
    output logic             pc_src,
    output logic             instr_done,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_next;
    iclass_t          r_class;
    iclass_t          w_class;
    logic             w_illegal;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    instr_class_decode u_decode (
        .i_opcode  (opcode),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_class <= CLS_R;
        end else if (r_state == ST_DECODE) begin
            r_class <= w_class;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired    = r_retired;
    assign instr_done = w_retire;

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_req   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_op     = ALUOP_ADD;
        alu_src    = 1'b0;
        reg2_loc   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        halted     = 1'b0;

        case (r_state)
            ST_RESET: w_next = ST_FETCH;

            ST_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                if (imem_ready) w_next = ST_DECODE;
            end

            ST_DECODE: begin
                if (w_illegal) begin
                    w_next = ST_HALT;
                end else begin
                    w_next   = ST_EXECUTE;
                    reg2_loc = (w_class == CLS_ST) || (w_class == CLS_CB);
                end
            end

            ST_EXECUTE: begin
                case (r_class)
                    CLS_R: begin
                        alu_op = ALUOP_RTYPE;
                        w_next = ST_WB;
                    end
                    CLS_SH: begin
                        alu_op  = ALUOP_SHIFT;
                        alu_src = 1'b1;
                        w_next  = ST_WB;
                    end
                    CLS_LD, CLS_ST: begin
                        alu_op  = ALUOP_ADD;
                        alu_src = 1'b1;
                        w_next  = ST_MEM;
                    end
                    CLS_CB: begin
                        alu_op   = ALUOP_PASS_B;
                        pc_write = 1'b1;
                        pc_src   = zero;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end
                    CLS_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end
                    default: w_next = ST_HALT;
                endcase
            end

            // Store retires in the completing MEM cycle, so PC update and retire
            // are qualified by dmem_ready to fire exactly once.
            ST_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (r_class == CLS_LD);
                mem_write = (r_class == CLS_ST);
                alu_op    = ALUOP_ADD;
                alu_src   = 1'b1;
                if (dmem_ready) begin
                    if (r_class == CLS_LD) begin
                        w_next = ST_WB;
                    end else begin
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (r_class == CLS_LD);
                pc_write   = 1'b1;
                w_retire   = 1'b1;
                w_next     = ST_FETCH;
            end

            ST_HALT: halted = 1'b1;

            default: w_next = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: per-instruction cycle schedules are
// built from the instruction-class timing rules and compared every cycle.
module tb_main_control_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [10:0]   opcode = '0;
    logic          zero = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, ir_write, dmem_req, mem_read, mem_write;
    logic [1:0]    alu_op;
    logic          alu_src, reg2_loc, reg_write, mem_to_reg, pc_write, pc_src;
    logic          instr_done, halted;
    logic [CW-1:0] retired;

    main_control_fsm #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .dmem_req   (dmem_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .reg2_loc   (reg2_loc),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    logic [CW-1:0] exp_ret = '0;

    logic          q_im[$];
    logic          q_dm[$];
    logic          q_z[$];
    logic [10:0]   q_op[$];
    logic [14:0]   q_exp[$];

    // {imem_req, ir_write, dmem_req, mem_read, mem_write, alu_op, alu_src,
    //  reg2_loc, reg_write, mem_to_reg, pc_write, pc_src, instr_done, halted}
    function automatic logic [14:0] ov(input logic req, input logic ir, input logic dreq,
                                       input logic mr, input logic mw, input logic [1:0] aop,
                                       input logic asrc, input logic r2, input logic rw,
                                       input logic m2r, input logic pw, input logic ps,
                                       input logic dn, input logic hl);
        return {req, ir, dreq, mr, mw, aop, asrc, r2, rw, m2r, pw, ps, dn, hl};
    endfunction

    function automatic logic [14:0] outs();
        return {imem_req, ir_write, dmem_req, mem_read, mem_write, alu_op, alu_src,
                reg2_loc, reg_write, mem_to_reg, pc_write, pc_src, instr_done, halted};
    endfunction

    // 0 R, 1 SH, 2 LD, 3 ST, 4 CB, 5 B, -1 illegal
    function automatic int classify(input logic [10:0] op);
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return 0;
        if (op == 11'b11010011011 || op == 11'b11010011010) return 1;
        if (op == 11'b11111000010) return 2;
        if (op == 11'b11111000000) return 3;
        if (op ==? 11'b10110100???) return 4;
        if (op ==? 11'b000101?????) return 5;
        return -1;
    endfunction

    function automatic logic [10:0] rand_legal();
        logic [10:0] t;
        case ($urandom_range(9, 0))
            0: t = 11'b10001011000;
            1: t = 11'b11001011000;
            2: t = 11'b10001010000;
            3: t = 11'b10101010000;
            4: t = 11'b11010011011;
            5: t = 11'b11010011010;
            6: t = 11'b11111000010;
            7: t = 11'b11111000000;
            8: t = {8'b10110100, 3'($urandom)};
            default: t = {6'b000101, 5'($urandom)};
        endcase
        return t;
    endfunction

    task automatic add_cycle(input logic im, input logic dm, input logic [10:0] op,
                             input logic z, input logic [14:0] e);
        q_im.push_back(im);
        q_dm.push_back(dm);
        q_op.push_back(op);
        q_z.push_back(z);
        q_exp.push_back(e);
    endtask

    // Entered and left at posedge+1 with the DUT in FETCH (or aborted by reset).
    task automatic do_instr(input string name, input logic [10:0] op, input int iw,
                            input int dw, input logic z, input int halt_cycles,
                            input int abort_at);
        int   cls = classify(op);
        logic ld  = (cls == 2);
        logic st  = (cls == 3);
        logic [14:0] act;
        q_im.delete(); q_dm.delete(); q_op.delete(); q_z.delete(); q_exp.delete();

        for (int i = 0; i < iw; i++)
            add_cycle(1'b0, 1'($urandom), 11'($urandom), 1'($urandom),
                      ov(1,0,0,0,0,2'd0,0,0,0,0,0,0,0,0));
        add_cycle(1'b1, 1'($urandom), 11'($urandom), 1'($urandom),
                  ov(1,1,0,0,0,2'd0,0,0,0,0,0,0,0,0));
        add_cycle(1'($urandom), 1'($urandom), op, 1'($urandom),
                  ov(0,0,0,0,0,2'd0,0,(cls == 3 || cls == 4),0,0,0,0,0,0));
        case (cls)
            -1: for (int i = 0; i < halt_cycles; i++)
                    add_cycle(1'($urandom), 1'($urandom), op, 1'($urandom),
                              ov(0,0,0,0,0,2'd0,0,0,0,0,0,0,0,1));
            0, 1: begin
                add_cycle(1'($urandom), 1'($urandom), op, 1'($urandom),
                          ov(0,0,0,0,0,(cls == 0) ? 2'd3 : 2'd2,(cls == 1),0,0,0,0,0,0,0));
                add_cycle(1'($urandom), 1'($urandom), op, 1'($urandom),
                          ov(0,0,0,0,0,2'd0,0,0,1,0,1,0,1,0));
            end
            2, 3: begin
                add_cycle(1'($urandom), 1'($urandom), op, 1'($urandom),
                          ov(0,0,0,0,0,2'd0,1,0,0,0,0,0,0,0));
                for (int i = 0; i < dw; i++)
                    add_cycle(1'($urandom), 1'b0, op, 1'($urandom),
                              ov(0,0,1,ld,st,2'd0,1,0,0,0,0,0,0,0));
                add_cycle(1'($urandom), 1'b1, op, 1'($urandom),
                          ov(0,0,1,ld,st,2'd0,1,0,0,0,st,0,st,0));
                if (ld)
                    add_cycle(1'($urandom), 1'($urandom), op, 1'($urandom),
                              ov(0,0,0,0,0,2'd0,0,0,1,1,1,0,1,0));
            end
            4: add_cycle(1'($urandom), 1'($urandom), op, z,
                         ov(0,0,0,0,0,2'd1,0,0,0,0,1,z,1,0));
            default: add_cycle(1'($urandom), 1'($urandom), op, 1'($urandom),
                               ov(0,0,0,0,0,2'd0,0,0,0,0,1,1,1,0));
        endcase

        for (int k = 0; k < q_exp.size(); k++) begin
            imem_ready = q_im[k];
            dmem_ready = q_dm[k];
            opcode     = q_op[k];
            zero       = q_z[k];
            @(negedge clk);
            act = outs();
            vectors++;
            if (act !== q_exp[k]) begin
                miscompares++;
                $display("FAIL %s outputs cycle %0d: got %b expected %b", name, k, act, q_exp[k]);
            end
            vectors++;
            if (retired !== exp_ret) begin
                miscompares++;
                $display("FAIL %s retired cycle %0d: got %0d expected %0d", name, k, retired, exp_ret);
            end
            if (k == abort_at) begin
                #2 reset_n = 1'b0;
                #1;
                vectors++;
                if (outs() !== 15'd0 || retired !== '0) begin
                    miscompares++;
                    $display("FAIL %s async abort: got %b/%0d expected 0/0", name, outs(), retired);
                end
                exp_ret = '0;
                return;
            end
            if (q_exp[k][1]) exp_ret = exp_ret + 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
            opcode = 11'($urandom); zero = 1'($urandom);
            @(negedge clk);
            vectors++;
            if (outs() !== 15'd0 || retired !== '0) begin
                miscompares++;
                $display("FAIL reset_hold: got %b/%0d expected 0/0", outs(), retired);
            end
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs() !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected 0", outs());
        end
        @(posedge clk); #1;
        exp_ret = '0;
    endtask

    task automatic test_add();
        do_instr("add", 11'b10001011000, 0, 0, 1'b0, 0, -1);
        vectors++;
        if (retired !== 4'd1) begin
            miscompares++;
            $display("FAIL add_retired: got %0d expected 1", retired);
        end
    endtask

    task automatic test_ldur_wait();
        do_instr("ldur_wait", 11'b11111000010, 0, 2, 1'b0, 0, -1);
        do_instr("ldur_iwait", 11'b11111000010, 3, 0, 1'b0, 0, -1);
    endtask

    task automatic test_cbz();
        do_instr("cbz_taken", 11'b10110100101, 0, 0, 1'b1, 0, -1);
        do_instr("cbz_not_taken", 11'b10110100011, 0, 0, 1'b0, 0, -1);
        do_instr("b", 11'b00010110110, 1, 0, 1'b0, 0, -1);
    endtask

    task automatic test_shift_store();
        do_instr("lsr", 11'b11010011010, 0, 0, 1'b0, 0, -1);
        do_instr("lsl", 11'b11010011011, 0, 0, 1'b0, 0, -1);
        do_instr("stur", 11'b11111000000, 0, 1, 1'b0, 0, -1);
    endtask

    task automatic test_halt();
        logic [CW-1:0] held;
        do_instr("halt", 11'b11111111111, 0, 0, 1'b0, 12, -1);
        held = exp_ret;
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (outs() !== 15'd0 || retired !== '0) begin
            miscompares++;
            $display("FAIL halt_reset: got %b/%0d expected 0/0 (was %0d)", outs(), retired, held);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        exp_ret = '0;
        @(negedge clk);
        vectors++;
        if (outs() !== 15'd0) begin
            miscompares++;
            $display("FAIL halt_release: got %b expected 0", outs());
        end
        @(posedge clk); #1;
        do_instr("after_halt", 11'b10101010000, 0, 0, 1'b0, 0, -1);
    endtask

    task automatic test_reset_mid();
        do_instr("stur_abort", 11'b11111000000, 0, 3, 1'b0, 0, 4);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs() !== 15'd0 || retired !== '0) begin
            miscompares++;
            $display("FAIL abort_release: got %b/%0d expected 0/0", outs(), retired);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 15; i++)
            do_instr("wrap_fill", rand_legal(), 0, 0, 1'($urandom), 0, -1);
        vectors++;
        if (retired !== 4'b1111) begin
            miscompares++;
            $display("FAIL wrap_full: got %0d expected 15", retired);
        end
        do_instr("wrap_last", 11'b11001011000, 0, 0, 1'b0, 0, -1);
        vectors++;
        if (retired !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap_zero: got %0d expected 0", retired);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            do_instr("random", rand_legal(), $urandom_range(3, 0), $urandom_range(3, 0),
                     1'($urandom), 0, -1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur_wait();
        test_cbz();
        test_shift_store();
        test_halt();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
